div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; result is 2*WIDTH.
REQ-002 SHALL have port clk  in  1  the only clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port dividend  in  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port divisor  in  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port annul  in  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port result  out  2*WIDTH  {remainder, quotient}, i.e. hi = remainder, lo = quotient.
REQ-010 SHALL have port ready  out  1  result valid, registered.
REQ-011 SHALL have port busy  out  1  division in progress, registered; pipeline stalls on it.

Function
REQ-012 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-013 IDLE: start=1, annul=0, divisor!=0 -> ON; latch operand magnitudes, signs and signed_div; clear iteration counter.
REQ-014 IDLE: start=1, annul=0, divisor==0 -> BYZERO.
REQ-015 IDLE: start=1 with annul=1 -> stay IDLE.
REQ-016 BYZERO: next edge -> END with result = 0.
REQ-017 ON: one restoring radix-2 iteration per cycle: shift partial remainder left 1 and bring in next dividend bit (MSB first); if partial >= divisor magnitude, subtract and shift quotient bit 1, else shift 0.
REQ-018 ON: after WIDTH iterations (counter WIDTH-1 -> WIDTH) -> END; result registered on that edge.
REQ-019 Latency: start accepted at edge N -> ready=1 from edge N+WIDTH+1 (N+33 for WIDTH=32); divide-by-zero: ready from edge N+2.
REQ-020 END: ready=1, result stable; stay in END while start=1; start=0 -> IDLE on next edge, ready drops on that edge.
REQ-021 Signed mode: divide magnitudes; quotient negated when operand signs differ; remainder takes the dividend's sign; all arithmetic modulo 2^WIDTH.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0 (wraps, no trap).
REQ-023 Unsigned mode: no sign conversion.
REQ-024 busy SHALL be 1 exactly in BYZERO and ON.
REQ-025 annul=1 in BYZERO, ON or END -> IDLE on next edge; ready, busy cleared; result not updated.
REQ-026 start, operand or signed_div changes during BYZERO/ON SHALL be ignored (latched copies only).
REQ-027 result SHALL hold its last value in IDLE until the next END or reset.
REQ-028 Downstream HI/LO write SHALL be qualified by ready; ready is not a single-cycle pulse guarantee (persists while start=1).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, result=0, ready=0, busy=0, counter=0, regardless of clock.
REQ-030 Reset asserted mid-operation SHALL discard it; first start after rst deassert is accepted normally.

Verification
REQ-031 Unsigned 100 / 7, start held -> busy 32 cycles, ready at edge N+33, result = {32'd2, 32'd14}.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; unsigned same operands -> {32'h1, 32'h7FFFFFFC}.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> result = {32'h0, 32'h80000000}, no error.
REQ-034 Divisor 0 -> BYZERO, ready at edge N+2, result = 0, busy high one cycle.
REQ-035 annul at 10th ON cycle -> IDLE next edge, ready never rises, prior result unchanged; new start 50/5 -> {32'd0, 32'd10}.
REQ-036 rst pulsed between edges mid-ON -> outputs 0 without clock edge; following 0xFFFFFFFF / 0x10 unsigned -> {32'hF, 32'h0FFFFFFF}.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes the signs when the result is registered.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;

   logic [WIDTH:0]       trial;
   logic                 ge;
   logic [WIDTH-1:0]     rem_nxt, quo_nxt, rem_fix, quo_fix;

   // quo_q doubles as the dividend shift register: its MSB feeds the partial
   // remainder while quotient bits enter at the LSB.
   always_comb begin
      trial   = {rem_q, quo_q[WIDTH-1]};
      ge      = trial >= {1'b0, dvs_q};
      rem_nxt = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], ge};
      rem_fix = negr_q ? -rem_nxt : rem_nxt;
      quo_fix = negq_q ? -quo_nxt : quo_nxt;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start && !annul) begin
               if (divisor == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d = ON;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
                  dvs_d   = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
                  negq_d  = signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  negr_d  = signed_div && dividend[WIDTH-1];
               end
            end
         end
         BYZERO: begin
            if (annul) begin
               state_d = IDLE;
            end else begin
               state_d  = END;
               result_d = '0;
            end
         end
         ON: begin
            if (annul) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               quo_d = quo_nxt;
               rem_d = rem_nxt;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d  = END;
                  result_d = {rem_fix, quo_fix};
               end
            end
         end
         END: begin
            if (annul || !start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == END);
      busy_d  = (state_d == BYZERO) || (state_d == ON);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign ready  = ready_q;
   assign busy   = busy_q;

endmodule
